// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-side handshake of the PS/2 host transmitter.
// The master modport is the command issuer. The slave modport is the transmitter.
interface ps2_host_tx_if;
    logic [7:0] TxData;
    logic       TxStart;
    logic       Busy;
    logic       Done;
    logic       Error;

    modport master (
        output TxData,
        output TxStart,
        input  Busy,
        input  Done,
        input  Error
    );

    modport slave (
        input  TxData,
        input  TxStart,
        output Busy,
        output Done,
        output Error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// It performs the request-to-send sequence: the clock is inhibited, then the start bit is placed.
// It shifts the byte out with odd parity on the falling edges of the device clock.
// It then checks the device ACK and reports Done or Error.
// Both PS/2 lines are open-drain: an Oe of 1 pulls the line low, and the block never drives a 1.
// Optional: define PS2_TX_TIMEOUT_EN to abort a frame when the device clock stalls.
// The bound is TIMEOUT_CYCLES and it is checked in XFER and WAIT_IDLE.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                CLK,
    input  logic                Resetn,
    ps2_host_tx_if.slave        host,
    input  logic                Ps2ClkIn,
    input  logic                Ps2DataIn,
    output logic                Ps2ClkOe,
    output logic                Ps2DataOe
);

    // The phase counter first times the inhibit phase.
    // With the timeout enabled, it then times the device clock.
    // It is sized for whichever of the two phases is longer.
    localparam int unsigned LP_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned LP_CNT_W   = $clog2(LP_CNT_MAX + 1);
    localparam logic [LP_CNT_W-1:0] LP_INHIBIT_LAST = LP_CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [LP_CNT_W-1:0] LP_TIMEOUT_LAST = LP_CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [7:0]             r_data;
    logic                   r_par;
    logic [3:0]             r_bit;
    logic [LP_CNT_W-1:0]    r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic                   r_clk_oe;
    logic                   r_data_oe;

    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_clk_fall;

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s   = r_data_sync[SYNC_STAGES-1];
    assign w_clk_fall = r_clk_prev & ~w_clk_s;

    assign host.Busy  = r_busy;
    assign host.Done  = r_done;
    assign host.Error = r_error;
    assign Ps2ClkOe   = r_clk_oe;
    assign Ps2DataOe  = r_data_oe;

    // Synchronize both PS/2 lines and keep the previous synced clock for edge detection.
    // The reset value is 1, the idle bus level, so that leaving reset creates no false edge.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_clk_sync  <= {SYNC_STAGES{1'b1}};
            r_data_sync <= {SYNC_STAGES{1'b1}};
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], Ps2ClkIn};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], Ps2DataIn};
            r_clk_prev  <= w_clk_s;
        end
    end

    // Frame sequencer: it drives the inhibit and request phases, the bit shifting, and the ACK check.
    // All outputs are registered.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= ST_IDLE;
            r_data    <= 8'h00;
            r_par     <= 1'b0;
            r_bit     <= 4'd0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (host.TxStart) begin
                        r_data   <= host.TxData;
                        r_par    <= ~^host.TxData;
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_INHIBIT;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (r_cnt == LP_INHIBIT_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_W'(1);
                    end
                end
                ST_REQ: begin
                    // Release the clock while the start bit stays on the data line.
                    r_clk_oe <= 1'b0;
                    r_bit    <= 4'd0;
                    r_cnt    <= '0;
                    r_state  <= ST_XFER;
                end
                ST_XFER: begin
                    if (w_clk_fall) begin
                        r_bit <= r_bit + 4'd1;
                        r_cnt <= '0;
                        case (r_bit)
                            4'd0, 4'd1, 4'd2, 4'd3,
                            4'd4, 4'd5, 4'd6, 4'd7: r_data_oe <= ~r_data[r_bit[2:0]];
                            4'd8:                   r_data_oe <= ~r_par;
                            4'd9:                   r_data_oe <= 1'b0;
                            default: begin
                                // This is the 11th edge. The device ACKs by holding data low.
                                if (!w_data_s) begin
                                    r_state <= ST_WAIT_IDLE;
                                end else begin
                                    r_error   <= 1'b1;
                                    r_busy    <= 1'b0;
                                    r_data_oe <= 1'b0;
                                    r_state   <= ST_IDLE;
                                end
                            end
                        endcase
`ifdef PS2_TX_TIMEOUT_EN
                    end else if (r_cnt == LP_TIMEOUT_LAST) begin
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_W'(1);
                    end
`else
                    end else begin
                        r_state <= ST_XFER;
                    end
`endif
                end
                ST_WAIT_IDLE: begin
                    if (w_clk_s && w_data_s) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`ifdef PS2_TX_TIMEOUT_EN
                    end else if (w_clk_fall) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LP_TIMEOUT_LAST) begin
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_W'(1);
                    end
`else
                    end else begin
                        r_state <= ST_WAIT_IDLE;
                    end
`endif
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, the host-side counterpart to the existing PS/2 receive path.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a keyboard or mouse.
- Uses the PS/2 request-to-send sequence, checks the device ACK, and reports Done or Error.
- Drives both PS/2 lines open-drain: output-enable high means pull low; release means the pull-up takes the line high.

Parameters:
- INHIBIT_CYCLES, 5000: system clocks the host holds PS/2 clock low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max system clocks between device clock falling edges, or while waiting for idle (15 ms at 50 MHz). Used only with PS2_TX_TIMEOUT_EN.
- SYNC_STAGES, 2: flip-flop stages on each PS/2 input; minimum 2.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- Resetn  input  1  asynchronous active-low reset.
- TxData  input  8  byte to send; sampled when TxStart is accepted.
- TxStart  input  1  one-cycle request; accepted only in IDLE.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle pulse: frame ACKed and bus idle.
- Error  output  1  one-cycle pulse: no ACK, or timeout.
- Ps2ClkIn  input  1  PS/2 clock line, async.
- Ps2DataIn  input  1  PS/2 data line, async.
- Ps2ClkOe  output  1  1 = pull PS/2 clock low.
- Ps2DataOe  output  1  1 = pull PS/2 data low.

Behaviour:
- Reset (async, Resetn low):
  - State goes to IDLE.
  - Busy, Done, Error, Ps2ClkOe, Ps2DataOe all 0.
  - Counters and synchronizers cleared; synchronizers reset to 1.
  - Reset mid-frame releases both lines immediately, with no Done or Error pulse.
- Inputs are synchronized through SYNC_STAGES flip-flops. Falling edge = previous synced clock 1 and current 0.
- Parity is odd: P = ~^TxData, computed at accept time.
- IDLE:
  - On TxStart, latch TxData and P and go to INHIBIT.
  - Busy = 1 from the next cycle.
  - TxStart while not in IDLE is ignored.
- INHIBIT:
  - Ps2ClkOe = 1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ (1 cycle):
  - Ps2ClkOe = 1 and Ps2DataOe = 1, which places the start bit (0).
  - Next state is XFER: Ps2ClkOe = 0, bit index n = 0.
- XFER, on each device clock falling edge:
  - n = 0..7: Ps2DataOe = ~TxData[n].
  - n = 8: Ps2DataOe = ~P.
  - n = 9: Ps2DataOe = 0 (stop bit, line released).
  - n increments after each edge.
- On the 11th falling edge (n = 10), sample synced data:
  - 0 = ACK: go to WAIT_IDLE.
  - 1 = no ACK: pulse Error, go to IDLE, Busy = 0 in the same cycle as the Error pulse.
- WAIT_IDLE:
  - Wait until synced clock and data are both 1.
  - Then pulse Done, go to IDLE, Busy = 0 in the same cycle as the Done pulse.
- Done and Error are never asserted together, and never pulse more than once per frame.
- Data changes only on falling edges; it is stable across every device rising edge.
- Lines are driven only by Oe signals. The block never drives a 1.

Optional Feature:
- Macro PS2_TX_TIMEOUT_EN.
- When defined:
  - A counter runs in XFER and WAIT_IDLE and is cleared on entering XFER and on each falling edge.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse Error, Busy = 0, go to IDLE.
- When not defined:
  - No counter is synthesized; XFER and WAIT_IDLE wait indefinitely.
  - Error comes only from a missing ACK.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- TxData = 0xED, TxStart; device model clocks (~12 kHz) and ACKs.
  - Ps2ClkOe high for 5000 cycles, then start bit 0.
  - Bits sampled on rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Done pulses once after lines idle; Busy falls with Done.
- TxData = 0x01 -> parity bit sampled 0; TxData = 0x00 -> parity 1; both end with Done.
- Device model leaves data high on the 11th clock -> Error pulses once, no Done, both Oe = 0, state back in IDLE.
- TxStart pulsed with TxData = 0xAA during XFER of 0xF4 -> ignored; the device receives 0xF4 only.
- Resetn low mid-frame after bit 3 -> Ps2ClkOe = Ps2DataOe = Busy = 0 asynchronously; no Done or Error; a new 0xFF frame after reset completes correctly.
- With PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES = 1000, device never clocks after REQ -> Error exactly 1000 cycles after entering XFER. Without the macro -> Busy stays 1.
